// File: rtl/branch_exec_unit.sv
// Single-cycle branch/jump resolution unit with a registered, back-pressurable result
// and saturating statistics counters for branch/JAL/JALR results.
module branch_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_target,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_misalign,
  output logic             out_link_we,
  output logic [XLEN-1:0]  out_link,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                   accept;
  logic                   handshake;
  logic signed [XLEN-1:0] rs1_s_p0;
  logic signed [XLEN-1:0] rs2_s_p0;
  logic [XLEN-1:0]        seq_pc_p0;
  logic [XLEN-1:0]        br_tgt_p0;
  logic [XLEN-1:0]        jalr_sum_p0;
  logic [XLEN-1:0]        target_p0;
  logic                   cond_p0;
  logic                   taken_p0;
  logic                   mis_p0;
  logic                   misal_p0;
  logic                   link_we_p0;
  logic                   is_cf_p0;
  logic                   is_cf_p1;

  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready && !flush;

  // Stage p0: combinational resolution of the incoming request
  always_comb begin
    rs1_s_p0    = in_rs1;
    rs2_s_p0    = in_rs2;
    seq_pc_p0   = in_pc + XLEN'(4);
    br_tgt_p0   = in_pc + in_imm;
    jalr_sum_p0 = in_rs1 + in_imm;
    cond_p0     = 1'b0;
    taken_p0    = 1'b0;
    target_p0   = seq_pc_p0;
    mis_p0      = 1'b0;
    link_we_p0  = 1'b0;
    is_cf_p0    = 1'b0;

    unique case (in_funct3)
      3'b000:  cond_p0 = (in_rs1 == in_rs2);
      3'b001:  cond_p0 = (in_rs1 != in_rs2);
      3'b100:  cond_p0 = (rs1_s_p0 <  rs2_s_p0);
      3'b101:  cond_p0 = (rs1_s_p0 >= rs2_s_p0);
      3'b110:  cond_p0 = (in_rs1 <  in_rs2);
      3'b111:  cond_p0 = (in_rs1 >= in_rs2);
      default: cond_p0 = 1'b0;
    endcase

    unique case (in_opcode)
      OP_BRANCH: begin
        is_cf_p0  = 1'b1;
        taken_p0  = cond_p0;
        target_p0 = cond_p0 ? br_tgt_p0 : seq_pc_p0;
        mis_p0    = (cond_p0 != in_pred_taken);
      end
      OP_JAL: begin
        is_cf_p0   = 1'b1;
        taken_p0   = 1'b1;
        target_p0  = br_tgt_p0;
        mis_p0     = !in_pred_taken;
        link_we_p0 = 1'b1;
      end
      OP_JALR: begin
        // Register-indirect targets are never predicted, so always count as mispredicted
        is_cf_p0   = 1'b1;
        taken_p0   = 1'b1;
        target_p0  = {jalr_sum_p0[XLEN-1:1], 1'b0};
        mis_p0     = 1'b1;
        link_we_p0 = 1'b1;
      end
      default: ;
    endcase

    misal_p0 = taken_p0 && target_p0[1];
  end

  // Stage p1: registered result and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_tag          <= '0;
      out_target       <= '0;
      out_taken        <= 1'b0;
      out_mispredict   <= 1'b0;
      out_misalign     <= 1'b0;
      out_link_we      <= 1'b0;
      out_link         <= '0;
      is_cf_p1         <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept) begin
        out_tag        <= in_tag;
        out_target     <= target_p0;
        out_taken      <= taken_p0;
        out_mispredict <= mis_p0;
        out_misalign   <= misal_p0;
        out_link_we    <= link_we_p0;
        out_link       <= seq_pc_p0;
        is_cf_p1       <= is_cf_p0;
      end

      if (handshake && is_cf_p1) begin
        stat_branches <= sat_inc(stat_branches);
        if (out_mispredict) stat_mispredicts <= sat_inc(stat_mispredicts);
      end
    end
  end

endmodule

// File: tb/tb_branch_exec_unit.sv
// Scoreboard bench for branch_exec_unit: expected results queued at acceptance,
// compared while held and retired on handshake or flush.
module tb_branch_exec_unit;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_pred_taken, out_ready;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [5:0]  in_tag;
  logic        out_valid, out_taken, out_mispredict, out_misalign, out_link_we;
  logic [5:0]  out_tag;
  logic [31:0] out_target, out_link;
  logic [15:0] stat_branches, stat_mispredicts;

  logic        s_in_ready, s_out_valid, s_out_taken, s_out_mispredict, s_out_misalign, s_out_link_we;
  logic [5:0]  s_out_tag;
  logic [31:0] s_out_target, s_out_link;
  logic [1:0]  s_stat_branches, s_stat_mispredicts;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] target;
    logic        taken, mis, misal, lwe, cf;
    logic [31:0] link;
  } exp_t;

  exp_t        q[$];
  int          exp_br, exp_mis;
  logic [5:0]  tag_ctr = 6'd0;

  always #5 clk = ~clk;

  branch_exec_unit #(.XLEN(32), .TAG_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_tag(in_tag), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_target(out_target),
    .out_taken(out_taken), .out_mispredict(out_mispredict), .out_misalign(out_misalign),
    .out_link_we(out_link_we), .out_link(out_link),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_exec_unit #(.XLEN(32), .TAG_W(6), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_tag(in_tag), .in_pred_taken(in_pred_taken),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_tag(s_out_tag), .out_target(s_out_target),
    .out_taken(s_out_taken), .out_mispredict(s_out_mispredict), .out_misalign(s_out_misalign),
    .out_link_we(s_out_link_we), .out_link(s_out_link),
    .stat_branches(s_stat_branches), .stat_mispredicts(s_stat_mispredicts)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic c;
    e.tag = in_tag; e.link = in_pc + 32'd4; e.target = in_pc + 32'd4;
    e.taken = 1'b0; e.mis = 1'b0; e.lwe = 1'b0; e.cf = 1'b0;
    if (in_opcode == OP_BR) begin
      case (in_funct3)
        3'd0:    c = (in_rs1 == in_rs2);
        3'd1:    c = (in_rs1 != in_rs2);
        3'd4:    c = ($signed(in_rs1) < $signed(in_rs2));
        3'd5:    c = !($signed(in_rs1) < $signed(in_rs2));
        3'd6:    c = (in_rs1 < in_rs2);
        3'd7:    c = !(in_rs1 < in_rs2);
        default: c = 1'b0;
      endcase
      e.cf = 1'b1; e.taken = c; e.mis = (c != in_pred_taken);
      if (c) e.target = in_pc + in_imm;
    end else if (in_opcode == OP_JAL) begin
      e.cf = 1'b1; e.taken = 1'b1; e.lwe = 1'b1; e.mis = !in_pred_taken;
      e.target = in_pc + in_imm;
    end else if (in_opcode == OP_JALR) begin
      e.cf = 1'b1; e.taken = 1'b1; e.lwe = 1'b1; e.mis = 1'b1;
      e.target = (in_rs1 + in_imm) & ~32'd1;
    end
    e.misal = e.taken && e.target[1];
    return e;
  endfunction

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit had;
    @(negedge clk);
    had = (q.size() != 0);
    chk("out_valid", out_valid, had);
    chk("in_ready", in_ready, !flush && (!had || out_ready));
    chk("stat_br", stat_branches, exp_br);
    chk("stat_mis", stat_mispredicts, exp_mis);
    chk("sat_br", s_stat_branches, (exp_br > 3) ? 3 : exp_br);
    chk("sat_mis", s_stat_mispredicts, (exp_mis > 3) ? 3 : exp_mis);
    if (had) begin
      chk("tag", out_tag, q[0].tag);
      chk("target", out_target, q[0].target);
      chk("taken", out_taken, q[0].taken);
      chk("mispredict", out_mispredict, q[0].mis);
      chk("misalign", out_misalign, q[0].misal);
      chk("link_we", out_link_we, q[0].lwe);
      chk("link", out_link, q[0].link);
      if (flush || out_ready) begin
        if (!flush && q[0].cf) begin
          exp_br++;
          if (q[0].mis) exp_mis++;
        end
        void'(q.pop_front());
      end
    end
    if (in_valid && !flush && (!had || out_ready)) q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic pred);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_pred_taken = pred; in_tag = tag_ctr;
    tag_ctr = tag_ctr + 6'd1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_target", out_target, 0);
    chk("rst_link", out_link, 0);
    chk("rst_flags", {out_taken, out_mispredict, out_misalign, out_link_we}, 0);
    chk("rst_stat", {stat_branches, stat_mispredicts}, 0);
    q.delete(); exp_br = 0; exp_mis = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int br0;
    logic [5:0] tag_a, tag_b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pred_taken = 1'b0;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_opcode = '0; in_funct3 = '0; in_tag = '0;
    #3;
    do_reset();

    // BEQ taken, predicted not-taken
    req(OP_BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("beq_valid", out_valid, 1);
    chk("beq_target", out_target, 32'h120);
    chk("beq_taken", out_taken, 1);
    chk("beq_mis", out_mispredict, 1);
    chk("beq_lwe", out_link_we, 0);
    cycle();

    // Signed vs unsigned compare of the same operands, back to back
    req(OP_BR, 3'b100, 32'h400, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    cycle();
    chk("blt_taken", out_taken, 1);
    req(OP_BR, 3'b110, 32'h400, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("bltu_taken", out_taken, 0);
    chk("bltu_target", out_target, 32'h404);
    cycle();

    // JALR with odd base producing a misaligned target
    req(OP_JALR, 3'b000, 32'h200, 32'h0, 32'h1003, 32'h0, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("jalr_target", out_target, 32'h1002);
    chk("jalr_misal", out_misalign, 1);
    chk("jalr_link", out_link, 32'h204);
    chk("jalr_lwe", out_link_we, 1);
    chk("jalr_mis", out_mispredict, 1);
    cycle();

    // Remaining opcodes/conditions, including PC wrap-around
    req(OP_JAL,  3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 1'b1); cycle();
    req(OP_ALU,  3'b000, 32'h300, 32'h10, 32'h1, 32'h1, 1'b1);      cycle();
    req(OP_BR,   3'b001, 32'h500, 32'hFFFF_FFF0, 32'h3, 32'h4, 1'b1); cycle();
    req(OP_BR,   3'b101, 32'h600, 32'h6, 32'h8000_0000, 32'h1, 1'b0); cycle();
    req(OP_BR,   3'b111, 32'h700, 32'h8, 32'h8000_0000, 32'h1, 1'b0); cycle();
    req(OP_BR,   3'b010, 32'h800, 32'h8, 32'h1, 32'h1, 1'b1);         cycle();
    in_valid = 1'b0;
    cycle();

    // Back-pressure: held result stays put and the next request waits
    out_ready = 1'b0;
    tag_a = tag_ctr;
    req(OP_BR, 3'b000, 32'h900, 32'h10, 32'h7, 32'h7, 1'b0);
    cycle();
    tag_b = tag_ctr;
    req(OP_JAL, 3'b000, 32'hA00, 32'h100, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", in_ready, 0);
      chk("bp_tag", out_tag, tag_a);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("bp_next_tag", out_tag, tag_b);
    cycle();

    // Flush beats both out_ready and a pending request
    req(OP_BR, 3'b000, 32'hB00, 32'h10, 32'h1, 32'h1, 1'b0);
    cycle();
    br0 = exp_br;
    flush = 1'b1;
    req(OP_JAL, 3'b000, 32'hC00, 32'h10, 32'h0, 32'h0, 1'b0);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_stat", stat_branches, br0);
    cycle();

    // Random traffic with random back-pressure and occasional flush
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: req(OP_BR, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        1: req(OP_JAL, 3'd0, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        2: req(OP_JALR, 3'd0, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        default: req(OP_ALU, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, 1'b0);
      endcase
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cycle();

    // Reset while a result is held, then saturate the narrow counters
    out_ready = 1'b0;
    req(OP_BR, 3'b000, 32'hD00, 32'h10, 32'h2, 32'h2, 1'b0);
    cycle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(OP_BR, 3'b000, 32'hE00 + 32'(i * 16), 32'h40, 32'h9, 32'h9, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("sat_br_final", s_stat_branches, 2'd3);
    chk("sat_mis_final", s_stat_mispredicts, 2'd3);
    chk("wide_br_final", stat_branches, 16'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter TAG_W, default 6, width of the instruction tag.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  pipeline kill; discards any held result.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  unit can accept a request this cycle.
REQ-009 in_pc, in_imm, in_rs1, in_rs2  in  XLEN each  PC, sign-extended immediate, source operands.
REQ-010 in_opcode  in  7 / in_funct3  in  3  instruction fields.
REQ-011 in_tag  in  TAG_W / in_pred_taken  in  1  tag and front-end prediction.
REQ-012 out_valid  out  1 / out_ready  in  1  result handshake.
REQ-013 out_tag  out  TAG_W / out_target  out  XLEN  tag and resolved next PC.
REQ-014 out_taken, out_mispredict, out_misalign, out_link_we  out  1 each  resolution flags.
REQ-015 out_link  out  XLEN  return address (PC+4).
REQ-016 stat_branches, stat_mispredicts  out  CNT_W each  statistics counters.

Function
REQ-017 Request accepted when in_valid && in_ready.
REQ-018 in_ready = !flush && (!out_valid || out_ready), combinational.
REQ-019 Latency: accepted request yields out_valid=1 on the next rising edge.
REQ-020 Outputs are registered and held stable while out_valid && !out_ready.
REQ-021 Held result without a new acceptance in the out_ready cycle: out_valid clears next edge.
REQ-022 Opcode 1100011 (branch): funct3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; 010/011 -> not taken.
REQ-023 Branch taken: target = in_pc+in_imm; not taken: target = in_pc+4; out_link_we=0.
REQ-024 Opcode 1101111 (JAL): taken=1, target = in_pc+in_imm, out_link_we=1.
REQ-025 Opcode 1100111 (JALR): taken=1, target = (in_rs1+in_imm) with bit 0 cleared, out_link_we=1.
REQ-026 Any other opcode: taken=0, target = in_pc+4, out_link_we=0, counters untouched.
REQ-027 out_link = in_pc+4 for every accepted request.
REQ-028 All additions modulo 2^XLEN; carry discarded; PC wrap-around permitted.
REQ-029 out_mispredict = (taken != in_pred_taken) for branch/JAL; always 1 for JALR; 0 otherwise.
REQ-030 out_misalign = taken && target[1]; result still delivered with the computed target.
REQ-031 flush high: out_valid=0 at next edge, no acceptance that cycle, counters unchanged for discarded result.
REQ-032 flush has priority over out_ready and in_valid in the same cycle.
REQ-033 stat_branches +1 per output handshake (out_valid && out_ready && !flush) of a branch/JAL/JALR result.
REQ-034 stat_mispredicts +1 on the same handshake when out_mispredict=1.
REQ-035 Both counters saturate at all-ones; no wrap.

Reset
REQ-036 rst_n low asynchronously clears out_valid and all output registers and counters to 0.
REQ-037 Reset mid-operation discards any held result; in_ready=1 once rst_n high and flush low.

Verification
REQ-038 BEQ pc=0x100, imm=0x20, rs1=rs2=5, pred=0 -> next cycle out_valid=1, target=0x120, taken=1, mispredict=1, link_we=0.
REQ-039 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, target=pc+4.
REQ-040 JALR rs1=0x1003, imm=0, pc=0x200 -> target=0x1002, misalign=1, link=0x204, link_we=1, mispredict=1.
REQ-041 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs constant, second request accepted only after out_ready=1.
REQ-042 flush while out_valid=1, out_ready=1 -> out_valid=0 next edge, stat_branches unchanged.
REQ-043 CNT_W=2, four taken mispredicted branches consumed -> stat_branches=3, stat_mispredicts=3 (saturated).
